// File: rtl/pca_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pca_pkg: constants, FSM state type and helpers shared by the PCA blocks     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pca_pkg;

  localparam int PCA_MATRIX_SIZE = 4;
  localparam int PCA_DATA_WIDTH  = 8;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } dqe_state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dqe_mag_compare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dqe_mag_compare: |elem| as unsigned, plus strict compare against max_mag   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dqe_mag_compare
  import pca_pkg::*;
#(
  parameter int DATA_WIDTH = PCA_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] elem_i,
  input  logic        [DATA_WIDTH-1:0] max_mag_i,
  output logic        [DATA_WIDTH-1:0] mag_o,
  output logic                         gt_o
);

  logic [DATA_WIDTH-1:0] w_raw;

  // Unsigned negate: the most negative value maps onto 2^(W-1) without overflow.
  always_comb begin
    w_raw = elem_i;
    mag_o = w_raw[DATA_WIDTH-1] ? (~w_raw + DATA_WIDTH'(1)) : w_raw;
    gt_o  = (mag_o > max_mag_i);
  end

endmodule
`default_nettype wire

// File: rtl/data_query_engine_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_query_engine_stream: streaming pivot search over an NxN covariance    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_query_engine_stream
  import pca_pkg::*;
#(
  parameter  int MATRIX_SIZE = PCA_MATRIX_SIZE,
  parameter  int DATA_WIDTH  = PCA_DATA_WIDTH,
  localparam int IDX_W       = idx_width(MATRIX_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic        [DATA_WIDTH-1:0] threshold,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [IDX_W-1:0]      p,
  output logic        [IDX_W-1:0]      q,
  output logic signed [DATA_WIDTH-1:0] c_pq,
  output logic signed [DATA_WIDTH-1:0] c_pp,
  output logic signed [DATA_WIDTH-1:0] c_qq,
  output logic                         converged
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

  dqe_state_t                  state_q, state_d;
  logic        [IDX_W-1:0]     row_q, row_d, col_q, col_d;
  logic        [DATA_WIDTH-1:0] max_mag_q, max_mag_d;
  logic        [IDX_W-1:0]     best_p_q, best_p_d, best_q_q, best_q_d;
  logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic signed [DATA_WIDTH-1:0] diag_q [MATRIX_SIZE];
  logic signed [DATA_WIDTH-1:0] diag_d [MATRIX_SIZE];

  logic                         out_valid_q, out_valid_d;
  logic        [IDX_W-1:0]      p_q, p_d, q_q, q_d;
  logic signed [DATA_WIDTH-1:0] c_pq_q, c_pq_d, c_pp_q, c_pp_d, c_qq_q, c_qq_d;
  logic                         conv_q, conv_d;

  logic [DATA_WIDTH-1:0] w_mag;
  logic                  w_gt;
  logic                  w_clear;

  dqe_mag_compare #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mag (
    .elem_i    (in_data),
    .max_mag_i (max_mag_q),
    .mag_o     (w_mag),
    .gt_o      (w_gt)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    max_mag_d   = max_mag_q;
    best_p_d    = best_p_q;
    best_q_d    = best_q_q;
    best_val_d  = best_val_q;
    diag_d      = diag_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    q_d         = q_q;
    c_pq_d      = c_pq_q;
    c_pp_d      = c_pp_q;
    c_qq_d      = c_qq_q;
    conv_d      = conv_q;
    w_clear     = 1'b0;

    case (state_q)
      COLLECT: begin
        if (flush) begin
          w_clear = 1'b1;
        end else if (in_valid) begin
          if (row_q == col_q) begin
            diag_d[row_q] = in_data;
          end
          if ((col_q > row_q) && w_gt) begin
            max_mag_d  = w_mag;
            best_p_d   = row_q;
            best_q_d   = col_q;
            best_val_d = in_data;
          end
          if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
          // The final element is diagonal, so trackers are already settled;
          // reading diag_d picks up the (N-1,N-1) write in the same cycle.
          if ((row_q == LAST_IDX) && (col_q == LAST_IDX)) begin
            state_d     = RESULT;
            out_valid_d = 1'b1;
            p_d         = best_p_q;
            q_d         = best_q_q;
            c_pq_d      = best_val_q;
            c_pp_d      = diag_d[best_p_q];
            c_qq_d      = diag_d[best_q_q];
            conv_d      = (max_mag_q <= threshold);
            w_clear     = 1'b1;
          end
        end
      end
      RESULT: begin
        if (flush || out_ready) begin
          state_d     = COLLECT;
          out_valid_d = 1'b0;
          w_clear     = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT;
        w_clear = 1'b1;
      end
    endcase

    if (w_clear) begin
      row_d      = '0;
      col_d      = '0;
      max_mag_d  = '0;
      best_p_d   = '0;
      best_q_d   = IDX_W'(1);
      best_val_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      row_q       <= '0;
      col_q       <= '0;
      max_mag_q   <= '0;
      best_p_q    <= '0;
      best_q_q    <= IDX_W'(1);
      best_val_q  <= '0;
      diag_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      p_q         <= '0;
      q_q         <= '0;
      c_pq_q      <= '0;
      c_pp_q      <= '0;
      c_qq_q      <= '0;
      conv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      max_mag_q   <= max_mag_d;
      best_p_q    <= best_p_d;
      best_q_q    <= best_q_d;
      best_val_q  <= best_val_d;
      diag_q      <= diag_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      q_q         <= q_d;
      c_pq_q      <= c_pq_d;
      c_pp_q      <= c_pp_d;
      c_qq_q      <= c_qq_d;
      conv_q      <= conv_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign q         = q_q;
  assign c_pq      = c_pq_q;
  assign c_pp      = c_pp_q;
  assign c_qq      = c_qq_q;
  assign converged = conv_q;

endmodule
`default_nettype wire

// File: tb/tb_data_query_engine_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_query_engine_stream: random + directed checks against a model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_data_query_engine_stream;

  typedef int mat_t [64];
  typedef struct {
    int p, q, cpq, cpp, cqq, conv, acc;
  } exp_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int sw_done = 0;
  int rmode = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_rst = 1'b1;
  logic flush, in_valid, in_ready, out_valid, out_ready, converged;
  logic [7:0] in_data, threshold, c_pq, c_pp, c_qq;
  logic [1:0] p, q;
  exp_t expq[$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_query_engine_stream #(.MATRIX_SIZE(4), .DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .q(q), .c_pq(c_pq), .c_pp(c_pp), .c_qq(c_qq), .converged(converged)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: scan the upper triangle row-major, strict > keeps the earliest tie.
  function automatic exp_t ref_model(input int n, input mat_t m, input int thr);
    exp_t e;
    int best, mg;
    best = 0; e.p = 0; e.q = 1; e.cpq = 0; e.acc = 0;
    for (int r = 0; r < n; r++)
      for (int c = r + 1; c < n; c++) begin
        mg = (m[r*n+c] < 0) ? -m[r*n+c] : m[r*n+c];
        if (mg > best) begin
          best = mg; e.p = r; e.q = c; e.cpq = m[r*n+c];
        end
      end
    e.cpp  = m[e.p*n+e.p];
    e.cqq  = m[e.q*n+e.q];
    e.conv = (best <= thr) ? 1 : 0;
    return e;
  endfunction

  function automatic mat_t mk(input int n, input int dg, input int off);
    mat_t m;
    for (int i = 0; i < 64; i++) m[i] = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        m[r*n+c] = (r == c) ? ((dg < 0) ? r + 1 : dg) : off;
    return m;
  endfunction

  function automatic mat_t rnd_mat(input int n, input int w);
    mat_t m;
    int mode;
    mode = int'($urandom_range(3));
    for (int i = 0; i < 64; i++) m[i] = 0;
    for (int i = 0; i < n * n; i++) begin
      if (mode == 0) m[i] = int'($urandom_range(8)) - 4;
      else           m[i] = int'($urandom_range((1 << w) - 1)) - (1 << (w - 1));
      if ($urandom_range(15) == 0) m[i] = -(1 << (w - 1));
    end
    return m;
  endfunction

  task automatic pin(input string nm, input exp_t e, input int ep, input int eq,
                     input int ecpq, input int ecpp, input int ecqq, input int econv);
    chk({nm, ".p"}, e.p, ep);       chk({nm, ".q"}, e.q, eq);
    chk({nm, ".c_pq"}, e.cpq, ecpq); chk({nm, ".c_pp"}, e.cpp, ecpp);
    chk({nm, ".c_qq"}, e.cqq, ecqq); chk({nm, ".conv"}, e.conv, econv);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_mat(input mat_t m, input int thr, input int gap);
    exp_t e;
    threshold = 8'(thr);
    for (int i = 0; i < 16; i++) begin
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0; step();
      end
      in_valid = 1'b1;
      in_data  = 8'(m[i]);
      for (int g = 0; g < 1000 && !in_ready; g++) step();
      if (!in_ready) begin
        chk("in_ready_timeout", int'(in_ready), 1);
        $fatal(1, "input stalled");
      end
      if (i == 15) begin
        e = ref_model(4, m, thr);
        e.acc = cyc + 1;
        expq.push_back(e);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int g = 0; g < 100 && !out_valid; g++) step();
    chk("wait_valid", int'(out_valid), 1);
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 2000 && (expq.size() > 0 || out_valid); g++) step();
    chk("drain", expq.size(), 0);
  endtask

  // out_ready policy: 0 always, 1 random, 2 after a 5-cycle stall, 3 never
  initial begin
    int vcnt;
    out_ready = 1'b0; vcnt = 0;
    forever begin
      @(posedge clk); #1;
      vcnt = out_valid ? vcnt + 1 : 0;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        2:       out_ready = (vcnt > 5);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", int'(in_ready), int'(!out_valid));
        if (expq.size() > 0 && cyc == expq[0].acc) chk("latency", int'(out_valid), 1);
        if (expq.size() == 0) chk("idle_valid", int'(out_valid), 0);
        else if (out_valid) begin
          chk("p", int'(p), expq[0].p);
          chk("q", int'(q), expq[0].q);
          chk("c_pq", int'($signed(c_pq)), expq[0].cpq);
          chk("c_pp", int'($signed(c_pp)), expq[0].cpp);
          chk("c_qq", int'($signed(c_qq)), expq[0].cqq);
          chk("converged", int'(converged), expq[0].conv);
          if (out_ready || flush) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    mat_t t1, t2, t3, t4, t5;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; threshold = '0;
    t1 = mk(4, 10, 5);  t1[1*4+3] = -50;  t1[3*4+1] = -50;
    t2 = mk(4, -1, 0);  t2[0*4+2] = 40;   t2[2*4+0] = 40;
    t2[1*4+2] = -40;    t2[2*4+1] = -40;  t2[2*4+3] = -128; t2[3*4+2] = -128;
    t3 = t2;            t3[2*4+3] = 0;    t3[3*4+2] = 0;
    t4 = mk(4, -1, 0);
    t5 = mk(4, -1, 1);  t5[0*4+3] = -3;   t5[3*4+0] = -3;

    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0); chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_p", int'(p), 0);       chk("rst_q", int'(q), 0);
    chk("rst_c_pq", int'(c_pq), 0); chk("rst_c_pp", int'(c_pp), 0);
    chk("rst_c_qq", int'(c_qq), 0); chk("rst_conv", int'(converged), 0);
    rst = 1'b0; sw_rst = 1'b0;

    pin("m_t1", ref_model(4, t1, 3), 1, 3, -50, 10, 10, 0);
    pin("m_t2", ref_model(4, t2, 10), 2, 3, -128, 3, 4, 0);
    pin("m_t3", ref_model(4, t3, 10), 0, 2, 40, 1, 3, 0);
    pin("m_t4", ref_model(4, t4, 0), 0, 1, 0, 1, 2, 1);
    pin("m_t5a", ref_model(4, t5, 3), 0, 3, -3, 1, 4, 1);
    pin("m_t5b", ref_model(4, t5, 2), 0, 3, -3, 1, 4, 0);

    rmode = 0; step();
    send_mat(t1, 3, 0);  send_mat(t2, 10, 0); send_mat(t3, 10, 0);
    send_mat(t4, 0, 0);  send_mat(t5, 3, 0);  send_mat(t5, 2, 0);
    wait_idle();

    // Partial matrix full of large values, then flush with a live element.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'sd127; step();
    end
    flush = 1'b1; in_data = 8'sd127; step();
    flush = 1'b0; in_valid = 1'b0;
    send_mat(t1, 3, 0);
    wait_idle();

    rmode = 3;
    send_mat(t2, 10, 0); wait_valid(); step(); step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_res_valid", int'(out_valid), 0);
    chk("flush_res_ready", int'(in_ready), 1);

    rmode = 0;
    send_mat(t3, 10, 0); wait_valid();
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_hs_valid", int'(out_valid), 0);

    rmode = 3;
    send_mat(t1, 3, 0); wait_valid(); step();
    rst = 1'b1; expq.delete(); #1;
    chk("arst_valid", int'(out_valid), 0); chk("arst_ready", int'(in_ready), 1);
    chk("arst_p", int'(p), 0);             chk("arst_c_pq", int'(c_pq), 0);
    step(); rst = 1'b0; step();

    rmode = 2;
    repeat (10) send_mat(rnd_mat(4, 8), int'($urandom_range(128)), 30);
    wait_idle();
    rmode = 1;
    repeat (200) send_mat(rnd_mat(4, 8), int'($urandom_range(128)), 25);
    wait_idle();

    for (int g = 0; g < 20000 && sw_done < 2; g++) step();
    chk("sweep_done", sw_done, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SN = (gi == 0) ? 2 : 8;
    localparam int SW = (gi == 0) ? 8 : 16;
    localparam int SI = $clog2(SN);

    logic s_iv, s_ir, s_ov, s_or, s_conv;
    logic [SW-1:0] s_d, s_thr, s_cpq, s_cpp, s_cqq;
    logic [SI-1:0] s_p, s_q;
    exp_t sq[$];

    data_query_engine_stream #(.MATRIX_SIZE(SN), .DATA_WIDTH(SW)) u_sw (
      .clk(clk), .rst(sw_rst), .flush(1'b0), .in_valid(s_iv), .in_ready(s_ir),
      .in_data(s_d), .threshold(s_thr), .out_valid(s_ov), .out_ready(s_or),
      .p(s_p), .q(s_q), .c_pq(s_cpq), .c_pp(s_cpp), .c_qq(s_cqq), .converged(s_conv)
    );

    initial begin
      s_or = 1'b0;
      forever begin
        @(posedge clk); #1;
        s_or = 1'($urandom_range(1));
      end
    end

    initial begin
      mat_t m;
      int thr;
      exp_t e;
      s_iv = 1'b0; s_d = '0; s_thr = '0;
      wait (!sw_rst);
      @(posedge clk); #1;
      repeat (20) begin
        m = rnd_mat(SN, SW);
        thr = int'($urandom_range(1 << (SW - 1)));
        s_thr = SW'(thr);
        for (int i = 0; i < SN * SN; i++) begin
          while (int'($urandom_range(99)) < 25) begin
            s_iv = 1'b0; @(posedge clk); #1;
          end
          s_iv = 1'b1;
          s_d  = SW'(m[i]);
          for (int g = 0; g < 1000 && !s_ir; g++) begin
            @(posedge clk); #1;
          end
          if (!s_ir) begin
            chk("sw_in_ready_timeout", int'(s_ir), 1);
            $fatal(1, "sweep input stalled");
          end
          if (i == SN * SN - 1) begin
            e = ref_model(SN, m, thr);
            e.acc = cyc + 1;
            sq.push_back(e);
          end
          @(posedge clk); #1;
        end
        s_iv = 1'b0;
      end
      for (int g = 0; g < 2000 && (sq.size() > 0 || s_ov); g++) begin
        @(posedge clk); #1;
      end
      chk("sw_drain", sq.size(), 0);
      sw_done++;
    end

    initial begin
      forever begin
        @(negedge clk);
        if (!sw_rst) begin
          chk("sw_in_ready", int'(s_ir), int'(!s_ov));
          if (sq.size() > 0 && cyc == sq[0].acc) chk("sw_latency", int'(s_ov), 1);
          if (sq.size() == 0) chk("sw_idle_valid", int'(s_ov), 0);
          else if (s_ov) begin
            chk("sw_p", int'(s_p), sq[0].p);
            chk("sw_q", int'(s_q), sq[0].q);
            chk("sw_c_pq", int'($signed(s_cpq)), sq[0].cpq);
            chk("sw_c_pp", int'($signed(s_cpp)), sq[0].cpp);
            chk("sw_c_qq", int'($signed(s_cqq)), sq[0].cqq);
            chk("sw_conv", int'(s_conv), sq[0].conv);
            if (s_or) void'(sq.pop_front());
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/data_query_engine_stream.md
Name: data_query_engine_stream

Overview:
Parametrised streaming successor to the fixed 4x4 data query engine. Accepts one covariance element per cycle from the TPU output stream in row-major order with a valid/ready handshake. Tracks the largest-magnitude off-diagonal element of the upper triangle and captures all diagonal elements. After the last element it presents p, q, c_pq, c_pp, c_qq and a convergence flag to the CORDIC engine through a valid/ready output handshake.

Parameters:
MATRIX_SIZE, 4, matrix dimension N; legal range is N >= 2.
DATA_WIDTH, 8, element width in bits; signed two's complement.
IDX_W, $clog2(MATRIX_SIZE), width of p/q and of the row/column counters; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous abort; discards the partial or held matrix
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data
in_data  in  DATA_WIDTH  signed matrix element, row-major
threshold  in  DATA_WIDTH  unsigned convergence threshold; stable for the whole matrix
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
p  out  IDX_W  row of max off-diagonal element
q  out  IDX_W  column of max off-diagonal element; always q > p
c_pq  out  DATA_WIDTH  signed value of the element at (p,q)
c_pp  out  DATA_WIDTH  signed diagonal element at (p,p)
c_qq  out  DATA_WIDTH  signed diagonal element at (q,q)
converged  out  1  high when |c_pq| <= threshold

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high. All outputs are 0 except in_ready, which is 1. The FSM enters COLLECT, counters row=col=0, trackers are initialised, and the diagonal array is cleared.
- Trackers initialise to max_mag=0, best_p=0, best_q=1, best_val=0. They re-initialise on entry to COLLECT.
- FSM COLLECT:
  - in_ready=1, out_valid=0.
  - An element is accepted when in_valid && in_ready.
  - If row==col, write diag[row].
  - If col>row, compute mag=|in_data| as an unsigned DATA_WIDTH-bit value. The most negative input maps to 2^(DATA_WIDTH-1) exactly, with no overflow.
  - If mag > max_mag (strict), update max_mag, best_p=row, best_q=col, best_val=in_data. Ties keep the earliest element.
  - Lower-triangle elements (col<row) are accepted and ignored, since the matrix is symmetric.
  - col increments per accepted element and wraps N-1 -> 0, incrementing row.
  - Acceptance of (N-1,N-1) moves the FSM to RESULT.
- FSM RESULT:
  - Entered the cycle after the last element is accepted; out_valid=1 from that cycle.
  - in_ready=0.
  - Outputs are registered and held stable while out_valid && !out_ready:
    - p=best_p, q=best_q, c_pq=best_val
    - c_pp=diag[best_p], c_qq=diag[best_q]
    - converged=(max_mag <= threshold)
  - The diag entry written by the final element must appear correctly in c_qq, using a bypass or a registered load.
  - Handshake completes on out_valid && out_ready. Next cycle: out_valid=0, COLLECT, counters and trackers cleared, in_ready=1.
  - Output port values after handshake are don't-care; the bench checks them only while out_valid=1.
- Latency: out_valid rises exactly 1 cycle after the last element is accepted. Minimum period is N*N + 1 cycles per matrix, plus output stall.
- Throughput: in_valid gaps pause the counters, with no data loss. out_ready may be held high permanently.
- Boundary cases:
  - All off-diagonals zero: p=0, q=1, c_pq=0, converged=1 for any threshold.
  - threshold=0 with any nonzero off-diagonal: converged=0.
  - flush in COLLECT: counters and trackers cleared next cycle; the element presented in the same cycle is dropped.
  - flush in RESULT: out_valid drops next cycle and the result is lost, with no handshake.
  - flush together with out_ready in RESULT: flush wins, but the consumer has already sampled the result.
  - rst mid-matrix or mid-result: immediate return to reset values.
  - out_ready while out_valid=0: ignored.

Decomposition:
- Shared package pca_pkg holds:
  - the FSM enum typedef dqe_state_t {COLLECT, RESULT}
  - the helper function idx_width(n), returning max(1, $clog2(n))
  - the default constants PCA_MATRIX_SIZE and PCA_DATA_WIDTH, shared with the TPU and CORDIC blocks
- One sub-module, dqe_mag_compare: combinational. It takes a signed element and the current max_mag, and returns the unsigned magnitude and a strict-greater flag. It is reused by the future pivot-search variants.

Test Plan:
- N=4, W=8: stream identity*10 with A(1,3)=A(3,1)=-50 and every other off-diagonal 5, threshold=3 -> out_valid 1 cycle after the 16th accept; p=1, q=3, c_pq=-50, c_pp=10, c_qq=10, converged=0.
- Tie plus most-negative case: A(0,2)=40, A(1,2)=-40, A(2,3)=-128, diag=1,2,3,4 -> p=2, q=3, c_pq=-128 (mag 128), c_pp=3, c_qq=4. A second run with A(2,3)=0 gives p=0, q=2 (earliest tie wins).
- All off-diagonals 0, threshold=0 -> p=0, q=1, c_pq=0, converged=1. Separately, max |off-diagonal|=3 with threshold=3 -> converged=1; with threshold=2 -> converged=0.
- Random in_valid gaps plus out_ready held low for 5 cycles -> outputs stable across the stall, in_ready=0, and the next matrix is accepted only after the handshake. Results match a software reference for 200 random matrices.
- flush asserted after element 7 of 16, then a full clean matrix -> the result reflects only the clean matrix. rst asserted in RESULT -> out_valid=0 immediately and in_ready=1.
- Parameter sweep N=2, W=8 and N=8, W=16 -> N*N accepts per result, out_valid latency 1 cycle, results correct against the reference model.
